// File: rtl/tile_grid_flip_ctrl_pkg.sv
// Shared types and default geometry for the tile memory-game controller.
package tile_grid_flip_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ONE,
      S_HOLD,
      S_DONE
   } tile_state_t;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned PIX_W   = 11;
   localparam int unsigned RGB_W   = 12;
   localparam int unsigned SCREEN_LIMIT = 4096;

   localparam int unsigned DEF_COLS        = 4;
   localparam int unsigned DEF_ROWS        = 2;
   localparam int unsigned DEF_X0          = 64;
   localparam int unsigned DEF_Y0          = 64;
   localparam int unsigned DEF_TILE_W      = 128;
   localparam int unsigned DEF_TILE_H      = 128;
   localparam int unsigned DEF_GAP         = 16;
   localparam int unsigned DEF_HOLD_CYCLES = 65_000_000;

   // Pair-id width; a single pair still needs one bit to hold its id.
   function automatic int unsigned pair_id_width(input int unsigned n);
      return (n > 2) ? $clog2(n / 2) : 1;
   endfunction

endpackage

// File: rtl/tile_grid_flip_ctrl_if.sv
// Mouse and pixel-stream bundle between the input/draw chain and the game controller.
interface tile_grid_flip_ctrl_if;
   import tile_grid_flip_ctrl_pkg::*;

   logic               mouse_left;
   logic [COORD_W-1:0] xpos;
   logic [COORD_W-1:0] ypos;
   logic [PIX_W-1:0]   hcount;
   logic [PIX_W-1:0]   vcount;
   logic [RGB_W-1:0]   rgb_in;
   logic [RGB_W-1:0]   rgb_face;
   logic [RGB_W-1:0]   rgb_back;
   logic [RGB_W-1:0]   rgb_out;

   modport master (
      output mouse_left, xpos, ypos, hcount, vcount, rgb_in, rgb_face, rgb_back,
      input  rgb_out
   );

   modport slave (
      input  mouse_left, xpos, ypos, hcount, vcount, rgb_in, rgb_face, rgb_back,
      output rgb_out
   );

endinterface

// File: rtl/tile_grid_flip_ctrl_hit.sv
// Combinational tile hit test: maps a coordinate to the tile it falls in, if any.
module tile_hit_decoder
   import tile_grid_flip_ctrl_pkg::*;
#(
   parameter int unsigned COLS   = DEF_COLS,
   parameter int unsigned ROWS   = DEF_ROWS,
   parameter int unsigned X0     = DEF_X0,
   parameter int unsigned Y0     = DEF_Y0,
   parameter int unsigned TILE_W = DEF_TILE_W,
   parameter int unsigned TILE_H = DEF_TILE_H,
   parameter int unsigned GAP    = DEF_GAP,
   parameter int unsigned IW     = $clog2(COLS * ROWS)
)
(
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [IW-1:0]      tile_idx,
   output logic               hit_valid
);

   logic [31:0]     xe;
   logic [31:0]     ye;
   logic [COLS-1:0] col_hit;
   logic [ROWS-1:0] row_hit;

   assign xe = 32'(x);
   assign ye = 32'(y);

   // Per-column and per-row range checks: start inclusive, end exclusive.
   always_comb begin
      col_hit = '0;
      row_hit = '0;
      for (int unsigned c = 0; c < COLS; c++) begin
         col_hit[c] = (xe >= X0 + c * (TILE_W + GAP)) &&
                      (xe <  X0 + c * (TILE_W + GAP) + TILE_W);
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
         row_hit[r] = (ye >= Y0 + r * (TILE_H + GAP)) &&
                      (ye <  Y0 + r * (TILE_H + GAP) + TILE_H);
      end
   end

   // Combine row and column hits into a linear tile index (row-major).
   always_comb begin
      hit_valid = 1'b0;
      tile_idx  = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            if (row_hit[r] && col_hit[c]) begin
               hit_valid = 1'b1;
               tile_idx  = IW'(r * COLS + c);
            end
         end
      end
   end

endmodule

// File: rtl/tile_grid_flip_ctrl.sv
// Memory-game controller: click detection, two-card flip/compare/hold FSM and
// per-pixel selection of face image, card back or background.
module tile_grid_flip_ctrl
   import tile_grid_flip_ctrl_pkg::*;
#(
   parameter int unsigned COLS        = DEF_COLS,
   parameter int unsigned ROWS        = DEF_ROWS,
   parameter int unsigned X0          = DEF_X0,
   parameter int unsigned Y0          = DEF_Y0,
   parameter int unsigned TILE_W      = DEF_TILE_W,
   parameter int unsigned TILE_H      = DEF_TILE_H,
   parameter int unsigned GAP         = DEF_GAP,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
)
(
   input  logic                     clk,
   input  logic                     rst,
   tile_grid_flip_ctrl_if.slave     bus,
   input  logic [COLS*ROWS*pair_id_width(COLS*ROWS)-1:0] pair_map,
   output logic [COLS*ROWS-1:0]     face_up,
   output logic [COLS*ROWS-1:0]     matched,
   output logic [pair_id_width(COLS*ROWS):0] pairs_found,
   output logic                     match_p,
   output logic                     miss_p,
   output logic                     done
);

   localparam int unsigned N  = COLS * ROWS;
   localparam int unsigned IW = $clog2(N);
   localparam int unsigned PW = pair_id_width(N);
   localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [PW:0]   PAIRS_ALL = (PW + 1)'(N / 2);

   if ((N < 2) || ((N % 2) != 0)) begin : g_bad_tile_count
      $error("tile_grid_flip_ctrl: COLS*ROWS must be even and at least 2");
   end
   if ((X0 + COLS * TILE_W + (COLS - 1) * GAP > SCREEN_LIMIT) ||
       (Y0 + ROWS * TILE_H + (ROWS - 1) * GAP > SCREEN_LIMIT)) begin : g_bad_geometry
      $error("tile_grid_flip_ctrl: tile grid does not fit 12-bit coordinates");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("tile_grid_flip_ctrl: HOLD_CYCLES must be at least 1");
   end

   tile_state_t       state_q, state_d;
   logic              btn_q;
   logic              click;
   logic              eligible;
   logic [IW-1:0]     first_q, first_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N-1:0]      up_q, up_d;
   logic [N-1:0]      mat_q, mat_d;
   logic [PW:0]       pairs_q, pairs_d;
   logic              mp_q, mp_d;
   logic              ms_q, ms_d;
   logic [PW-1:0]     pid_first, pid_click;

   logic [IW-1:0]     m_idx;
   logic              m_hit;
   logic [IW-1:0]     p_idx;
   logic              p_hit;
   logic [RGB_W-1:0]  rgb_q;

   tile_hit_decoder #(
      .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0),
      .TILE_W(TILE_W), .TILE_H(TILE_H), .GAP(GAP), .IW(IW)
   ) u_mouse_hit (
      .x         (bus.xpos),
      .y         (bus.ypos),
      .tile_idx  (m_idx),
      .hit_valid (m_hit)
   );

   tile_hit_decoder #(
      .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0),
      .TILE_W(TILE_W), .TILE_H(TILE_H), .GAP(GAP), .IW(IW)
   ) u_pixel_hit (
      .x         ({1'b0, bus.hcount}),
      .y         ({1'b0, bus.vcount}),
      .tile_idx  (p_idx),
      .hit_valid (p_hit)
   );

   // A click is the cycle where the button is high and was low last cycle;
   // holding the button while dragging therefore never re-triggers.
   assign click     = bus.mouse_left && !btn_q;
   assign eligible  = click && m_hit && !up_q[m_idx] && !mat_q[m_idx];
   assign pid_first = pair_map[first_q*PW +: PW];
   assign pid_click = pair_map[m_idx*PW +: PW];

   // Button history for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q <= 1'b0;
      end else begin
         btn_q <= bus.mouse_left;
      end
   end

   // Game state register: FSM, first pick, hold timer, tile masks, pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         first_q <= '0;
         cnt_q   <= '0;
         up_q    <= '0;
         mat_q   <= '0;
         pairs_q <= '0;
         mp_q    <= 1'b0;
         ms_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         cnt_q   <= cnt_d;
         up_q    <= up_d;
         mat_q   <= mat_d;
         pairs_q <= pairs_d;
         mp_q    <= mp_d;
         ms_q    <= ms_d;
      end
   end

   // Next-state logic: flip first card, compare second, hold a mismatch, finish.
   always_comb begin
      state_d = state_q;
      first_d = first_q;
      cnt_d   = cnt_q;
      up_d    = up_q;
      mat_d   = mat_q;
      pairs_d = pairs_q;
      mp_d    = 1'b0;
      ms_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (eligible) begin
               up_d[m_idx] = 1'b1;
               first_d     = m_idx;
               state_d     = S_ONE;
            end
         end
         S_ONE: begin
            // The first card is already face-up, so it is never eligible here.
            if (eligible) begin
               if (pid_first == pid_click) begin
                  mat_d[first_q] = 1'b1;
                  mat_d[m_idx]   = 1'b1;
                  up_d           = '0;
                  pairs_d        = pairs_q + (PW + 1)'(1);
                  mp_d           = 1'b1;
                  state_d        = (pairs_d == PAIRS_ALL) ? S_DONE : S_IDLE;
               end else begin
                  up_d[m_idx] = 1'b1;
                  ms_d        = 1'b1;
                  cnt_d       = HOLD_LOAD;
                  state_d     = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               up_d    = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output pixel register: face if revealed, back if covered, else background.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_q <= '0;
      end else if (p_hit && (up_q[p_idx] || mat_q[p_idx])) begin
         rgb_q <= bus.rgb_face;
      end else if (p_hit) begin
         rgb_q <= bus.rgb_back;
      end else begin
         rgb_q <= bus.rgb_in;
      end
   end

   assign bus.rgb_out = rgb_q;
   assign face_up     = up_q;
   assign matched     = mat_q;
   assign pairs_found = pairs_q;
   assign match_p     = mp_q;
   assign miss_p      = ms_q;
   assign done        = (state_q == S_DONE);

endmodule
